// File: rtl/pwm_capture.sv
// pwm_capture: receive-side PWM decoder.
//   Synchronizes an asynchronous PWM input, then measures each complete PWM
//   cycle (rise to next rise) in clk cycles. It publishes period and high
//   time with a one-cycle valid strobe. It flags a stuck input when no
//   complete cycle is seen within 2^WIDTH-1 cycles.
// Ports:
//   clk          system clock, posedge
//   reset        asynchronous active-low reset
//   pwm_in       asynchronous PWM input
//   enable       measurement enable; low forces IDLE and clears counters
//   period       last measured period (clk cycles)
//   duty         last measured high time (clk cycles)
//   valid        one-cycle strobe when period/duty update
//   stuck        no complete cycle within 2^WIDTH-1 cycles
//   stuck_level  synchronized input level when stuck was raised
module pwm_capture #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    input  logic             enable,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] duty,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_pwm;
    logic                   s_prev;
    logic                   rise;
    logic                   fall;
    logic [1:0]             state;
    logic [WIDTH-1:0]       cnt;
    logic [WIDTH-1:0]       hcnt;

    // Synchronizer and edge-detect flop keep running while disabled, so that
    // s_prev is valid on re-enable and no false edge appears then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_prev <= s_pwm;
        end
    end

    assign s_pwm = sync_q[SYNC_STAGES-1];
    assign rise  = s_pwm & ~s_prev;
    assign fall  = ~s_pwm & s_prev;

    // cnt doubles as the idle-cycle counter in IDLE. It saturates there, so
    // the stuck flag is raised once per IDLE entry and never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hcnt        <= '0;
            period      <= '0;
            duty        <= '0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                cnt   <= '0;
                hcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= HIGH;
                            cnt   <= CNT_ONE;
                            hcnt  <= CNT_ONE;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                            if (cnt == CNT_MAX - CNT_ONE) begin
                                stuck       <= 1'b1;
                                stuck_level <= s_pwm;
                            end
                        end
                    end
                    HIGH: begin
                        // A rise cannot occur while high, so saturation
                        // is checked first here.
                        if (cnt == CNT_MAX) begin
                            stuck       <= 1'b1;
                            stuck_level <= s_pwm;
                            state       <= IDLE;
                            cnt         <= '0;
                            hcnt        <= '0;
                        end else if (fall) begin
                            state <= LOW;
                            cnt   <= cnt + CNT_ONE;
                        end else begin
                            cnt  <= cnt + CNT_ONE;
                            hcnt <= hcnt + CNT_ONE;
                        end
                    end
                    LOW: begin
                        // A rise takes priority over saturation. That lets
                        // a period of exactly CNT_MAX complete normally.
                        if (rise) begin
                            period <= cnt;
                            duty   <= hcnt;
                            valid  <= 1'b1;
                            stuck  <= 1'b0;
                            state  <= HIGH;
                            cnt    <= CNT_ONE;
                            hcnt   <= CNT_ONE;
                        end else if (cnt == CNT_MAX) begin
                            stuck       <= 1'b1;
                            stuck_level <= s_pwm;
                            state       <= IDLE;
                            cnt         <= '0;
                            hcnt        <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        hcnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: directed PWM waveforms. The driver pushes the
// expected measurement of each completed cycle into a queue. A monitor pops
// and compares on every valid strobe.
module tb_pwm_capture;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         pwm_in = 1'b0;
    logic         enable = 1'b1;
    logic [W-1:0] period;
    logic [W-1:0] duty;
    logic         valid;
    logic         stuck;
    logic         stuck_level;

    pwm_capture #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .pwm_in(pwm_in), .enable(enable),
        .period(period), .duty(duty), .valid(valid),
        .stuck(stuck), .stuck_level(stuck_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        int h;
    } meas_t;

    meas_t expq[$];
    meas_t mon_e;
    int    checks = 0;
    int    failures = 0;
    int    prev_p = 0;
    int    prev_h = 0;
    bit    armed = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid period=%0d duty=%0d expected=no valid",
                         period, duty);
            end else begin
                mon_e = expq.pop_front();
                chk("valid_period", int'(period), mon_e.p);
                chk("valid_duty", int'(duty), mon_e.h);
                chk("valid_stuck_clear", int'(stuck), 0);
            end
        end
    end

    // One PWM cycle of p clocks with h high. kind: 0 plain, 1 enable drop at
    // clock 'at' for 'len' clocks, 2 reset pulse at 'at' for 'len' clocks.
    // The rise that starts this cycle completes the previous one.
    task automatic pwm_cycle(input int p, input int h, input int kind,
                             input int at, input int len);
        if (armed) expq.push_back('{prev_p, prev_h});
        for (int i = 0; i < p; i++) begin
            pwm_in = (i < h);
            if (kind == 1 && i == at) enable = 1'b0;
            if (kind == 1 && i == at + len - 1) begin
                chk("hold_period", int'(period), prev_p);
                chk("hold_duty", int'(duty), prev_h);
            end
            if (kind == 1 && i == at + len) enable = 1'b1;
            if (kind == 2 && i == at) begin
                reset = 1'b0;
                #1;
                chk("rst_mid_period", int'(period), 0);
                chk("rst_mid_duty", int'(duty), 0);
                chk("rst_mid_valid", int'(valid), 0);
                chk("rst_mid_stuck", int'(stuck), 0);
                chk("rst_mid_level", int'(stuck_level), 0);
            end
            if (kind == 2 && i == at + len) reset = 1'b1;
            @(negedge clk);
        end
        prev_p = p;
        prev_h = h;
        armed  = (kind == 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_period", int'(period), 0);
        chk("reset_duty", int'(duty), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_stuck", int'(stuck), 0);
        chk("reset_level", int'(stuck_level), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // 1: maximum period 255 / 127, rise coincides with saturation threshold
        repeat (10) pwm_cycle(255, 127, 0, 0, 0);

        // 2: duty change 1 -> 9 at constant period 10
        repeat (3) pwm_cycle(10, 1, 0, 0, 0);
        repeat (3) pwm_cycle(10, 9, 0, 0, 0);

        // 3: stuck high after one rise. The rise is seen 2 clocks after pwm_in
        //    goes high, and stuck follows 255 clocks after that.
        if (armed) expq.push_back('{prev_p, prev_h});
        armed  = 1'b0;
        pwm_in = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 257) chk("stuck_hi_early", int'(stuck), 0);
            if (k == 258) begin
                chk("stuck_hi", int'(stuck), 1);
                chk("stuck_hi_level", int'(stuck_level), 1);
                chk("stuck_hi_period", int'(period), 10);
                chk("stuck_hi_duty", int'(duty), 9);
            end
        end
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        pwm_cycle(20, 5, 0, 0, 0);
        chk("stuck_before_resume", int'(stuck), 1);
        repeat (2) pwm_cycle(20, 5, 0, 0, 0);
        chk("stuck_after_resume", int'(stuck), 0);

        // 4: held low from reset. The idle counter raises stuck at the 255th
        //    clock.
        reset  = 1'b0;
        armed  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            if (k == 254) chk("stuck_lo_early", int'(stuck), 0);
            if (k == 255) begin
                chk("stuck_lo", int'(stuck), 1);
                chk("stuck_lo_level", int'(stuck_level), 0);
                chk("stuck_lo_period", int'(period), 0);
            end
        end

        // 5: reset mid-high in period 50 / 25. Release happens while low.
        repeat (3) pwm_cycle(50, 25, 0, 0, 0);
        pwm_cycle(50, 25, 2, 10, 25);
        repeat (3) pwm_cycle(50, 25, 0, 0, 0);

        // 6: period 40, enable dropped for 17 clocks mid-cycle
        repeat (3) pwm_cycle(40, 13, 0, 0, 0);
        pwm_cycle(40, 13, 1, 5, 17);
        repeat (3) pwm_cycle(40, 13, 0, 0, 0);

        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("outstanding_expected", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
